// File: rtl/a2bus_capture_fifo.sv
// Captures Apple II bus writes (and reads when A2BUS_CAPTURE_READS_EN is defined) within [ADDR_LO, ADDR_HI] into a FWFT FIFO.
// Head is visible one cycle after the strobe; when the FIFO is full, a match is dropped and counted unless a pop happens in the same cycle.
module a2bus_capture_fifo #(
   parameter int unsigned DEPTH   = 16,
   parameter logic [15:0] ADDR_LO = 16'hC080,
   parameter logic [15:0] ADDR_HI = 16'hC0FF
) (
   input  logic                       clk_logic_i,
   input  logic                       system_reset_n_i,
   input  logic [15:0]                addr_i,
   input  logic [7:0]                 data_i,
   input  logic                       rw_n_i,
   input  logic                       data_in_strobe_i,
   output logic                       entry_valid_o,
   input  logic                       entry_ready_i,
   output logic [15:0]                entry_addr_o,
   output logic [7:0]                 entry_data_o,
   output logic                       entry_rw_n_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       overflow_o,
   output logic [7:0]                 drop_count_o,
   input  logic                       clear_overflow_i
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef struct packed {
      logic        rw_n;
      logic [15:0] addr;
      logic [7:0]  data;
   } entry_t;

   entry_t        mem [DEPTH];
   entry_t        wr_entry;
   entry_t        head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          in_window;
   logic          rw_ok;
   logic          match;
   logic          full;
   logic          push;
   logic          pop;
   logic          drop;

   assign in_window = (addr_i >= ADDR_LO) && (addr_i <= ADDR_HI);

`ifdef A2BUS_CAPTURE_READS_EN
   assign rw_ok = 1'b1;
`else
   // Reads never reach the queue, so they cannot overflow it either.
   assign rw_ok = ~rw_n_i;
`endif

   assign match         = data_in_strobe_i && in_window && rw_ok;
   assign full          = (count_o == CW'(DEPTH));
   assign entry_valid_o = (count_o != '0);
   assign pop           = entry_valid_o && entry_ready_i;
   assign push          = match && (!full || pop);
   assign drop          = match && full && !pop;

   assign wr_entry = '{rw_n: rw_n_i, addr: addr_i, data: data_i};
   assign head     = mem[rd_ptr];

   assign entry_addr_o = entry_valid_o ? head.addr : 16'h0000;
   assign entry_data_o = entry_valid_o ? head.data : 8'h00;
   assign entry_rw_n_o = entry_valid_o ? head.rw_n : 1'b0;

   // Storage carries no reset; validity is tracked by count_o alone.
   always_ff @(posedge clk_logic_i) begin
      if (push) begin
         mem[wr_ptr] <= wr_entry;
      end
   end

   always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
      if (!system_reset_n_i) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count_o <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
         end
         case ({push, pop})
            2'b10:   count_o <= count_o + CW'(1);
            2'b01:   count_o <= count_o - CW'(1);
            default: count_o <= count_o;
         endcase
      end
   end

   // A drop coinciding with a clear restarts the count at one.
   always_ff @(posedge clk_logic_i or negedge system_reset_n_i) begin
      if (!system_reset_n_i) begin
         overflow_o   <= 1'b0;
         drop_count_o <= 8'h00;
      end else if (drop) begin
         overflow_o <= 1'b1;
         if (clear_overflow_i) begin
            drop_count_o <= 8'h01;
         end else if (drop_count_o != 8'hFF) begin
            drop_count_o <= drop_count_o + 8'h01;
         end
      end else if (clear_overflow_i) begin
         overflow_o   <= 1'b0;
         drop_count_o <= 8'h00;
      end
   end

endmodule

// File: doc/a2bus_capture_fifo.md
# a2bus_capture_fifo

Downstream consumer of the Apple II bus interface. It watches the latched bus address, data and R/W together with the one-cycle data-valid strobe, and filters transactions against a configurable address window. Matching transactions are queued in a first-word-fall-through FIFO, which the card's soft-switch and register logic drains through a valid/ready handshake. Lost transactions are reported through a sticky overflow flag and a saturating drop counter.

## Interface
Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two and at least 2.
- ADDR_LO, 16'hC080, lowest address captured (inclusive).
- ADDR_HI, 16'hC0FF, highest address captured (inclusive); must satisfy ADDR_HI >= ADDR_LO.

Ports:
- clk_logic_i  in  1  logic clock, the same domain as the bus interface.
- system_reset_n_i  in  1  reset, asynchronous assert, active-low.
- addr_i  in  16  latched bus address, held stable between samples.
- data_i  in  8  latched bus data, valid when data_in_strobe_i is high.
- rw_n_i  in  1  latched R/W: 1 = read, 0 = write.
- data_in_strobe_i  in  1  one-cycle pulse, at most one per Apple cycle.
- entry_valid_o  out  1  FIFO head is valid.
- entry_ready_i  in  1  consumer accepts the head.
- entry_addr_o  out  16  head address; 0 when entry_valid_o is 0.
- entry_data_o  out  8  head data; 0 when entry_valid_o is 0.
- entry_rw_n_o  out  1  head R/W; 0 when entry_valid_o is 0.
- count_o  out  $clog2(DEPTH)+1  current number of entries.
- overflow_o  out  1  sticky flag: a matching transaction was dropped.
- drop_count_o  out  8  number of dropped transactions, saturates at 255.
- clear_overflow_i  in  1  clears overflow_o and drop_count_o.

## Operation
- match = data_in_strobe_i && ADDR_LO <= addr_i <= ADDR_HI && (rw_n_i == 0, unless reads are enabled; see Configuration).
- Storage: DEPTH x 25-bit array {rw_n, addr, data}; write pointer wr_ptr and read pointer rd_ptr, each $clog2(DEPTH) bits, wrap modulo DEPTH. The array itself is not reset.
- push = match && (count_o < DEPTH || pop). A push writes mem[wr_ptr] and then increments wr_ptr.
- pop = entry_valid_o && entry_ready_i. A pop increments rd_ptr.
- count_o: push only → +1; pop only → −1; push and pop together → unchanged.
- Full (count_o == DEPTH), match and no pop: the transaction is dropped. overflow_o is set to 1 and drop_count_o increments, saturating at 255.
- Full, match and pop in the same cycle: the push is accepted and there is no drop.
- Empty (count_o == 0): pop is impossible, because entry_valid_o is 0 and entry_ready_i is ignored.
- entry_valid_o = (count_o != 0). The entry_* outputs show mem[rd_ptr] combinationally, gated to 0 when entry_valid_o is 0.
- clear_overflow_i clears both overflow_o and drop_count_o on the next edge. If a drop occurs in the same cycle, the drop wins: overflow_o = 1 and drop_count_o = 1.
- A match with ADDR_LO == ADDR_HI captures exactly that one address.

## Timing
- Reset asserted: wr_ptr, rd_ptr and count_o go to 0 immediately, so entry_valid_o = 0 and all entry_* outputs = 0. overflow_o = 0 and drop_count_o = 0.
- Reset asserted mid-operation discards all queued entries. Any in-flight strobe is lost and is not counted as a drop.
- Push latency: a strobe sampled at edge N gives entry_valid_o = 1 with the head data visible after edge N, i.e. usable in cycle N+1.
- Pop: the head advances on the edge where entry_valid_o && entry_ready_i. The next entry is visible in the following cycle; entry_valid_o stays high if count_o > 1.
- Back-to-back pops at one per clock are supported.
- Pushes arrive at most once per bus strobe (about one per 52 clocks at 54 MHz). The design still accepts a push on every clock.
- There is no combinational path from entry_ready_i to entry_valid_o.

## Configuration
- A2BUS_CAPTURE_READS_EN defined: matching read transactions (rw_n_i = 1) are queued as well as writes, and entry_rw_n_o distinguishes them.
- Undefined (default): only writes are queued. Reads are ignored completely, never count as drops, and entry_rw_n_o is always 0 for valid entries.

## Test plan
- Single write: a strobe with addr C080, data 5A, rw_n 0 → next cycle entry_valid_o = 1, entry_addr_o = C080, entry_data_o = 5A, count_o = 1. Pulse ready → count_o = 0, entry_* = 0.
- Window filter: strobes at C07F, C100 and C0FF → only C0FF is queued; count_o = 1.
- Overflow: hold ready low and send 18 writes with DEPTH = 16 → count_o = 16, overflow_o = 1, drop_count_o = 2. The head still holds write #1. Pulse clear_overflow_i → overflow_o = 0, drop_count_o = 0.
- Full with simultaneous pop and push: the write is accepted, count_o stays 16, no drop. Draining returns entries 2..17 in order, exercising pointer wrap.
- Read strobe at C0E0: without the macro → nothing is queued. With A2BUS_CAPTURE_READS_EN → the entry is queued with entry_rw_n_o = 1.
- Assert reset with 5 entries queued → count_o = 0, entry_valid_o = 0, overflow_o = 0 immediately, without waiting for a clock.
